i2c_slave_regfile: RTL

Synthesizable, parametrised I2C slave with an internal byte-wide register file. It is the RTL successor to the behavioural slave model that sits opposite the APB-controlled i2c_top master in the verification top. It adds:
- a configurable 7-bit address;
- a register pointer with auto-increment and wrap;
- pointer range checking;
- a local observation/write-notification port.

Bus pins are split (input / open-drain enable); the top level builds the inout.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_slave_regfile_if.sv | 11 +
 rtl/i2c_bus_sync.sv | 44 ++++
 rtl/i2c_slave_regfile.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared constants and FSM state type for the I2C slave register file.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned BYTE_W     = 8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_slave_regfile_if.sv
// Split I2C pin bundle: pin levels in, open-drain SDA pull enable out.
interface i2c_slave_regfile_if;

    logic scl_i;
    logic sda_i;
    logic sda_oe_o;

    modport master (output scl_i, output sda_i, input sda_oe_o);
    modport slave  (input scl_i, input sda_i, output sda_oe_o);

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the core clock and derives SCL edge and START/STOP strobes.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Reset to the idle-bus level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_i};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_i};
            scl_d  <= scl_ff[SYNC_STAGES-1];
            sda_d  <= sda_ff[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_ff[SYNC_STAGES-1];
    assign sda_s     = sda_ff[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave with a byte-wide register file, auto-incrementing pointer and local debug/notify ports.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int unsigned           REG_DEPTH   = 16,
    parameter int unsigned           PTR_W       = $clog2(REG_DEPTH),
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic                 i2c_core_clk_i,
    input  logic                 preset_n_i,
    i2c_slave_regfile_if.slave   bus,
    output logic                 start_o,
    output logic                 stop_o,
    output logic                 busy_o,
    output logic                 wr_strobe_o,
    output logic [PTR_W-1:0]     wr_addr_o,
    output logic [BYTE_W-1:0]    wr_data_o,
    input  logic [PTR_W-1:0]     dbg_addr_i,
    output logic [BYTE_W-1:0]    dbg_data_o
);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(REG_DEPTH - 1);
    localparam logic [BYTE_W:0]  DEPTH_EXT = (BYTE_W + 1)'(REG_DEPTH);

    i2c_state_e        state_q, state_n;
    logic [3:0]        cnt_q, cnt_n;
    logic [BYTE_W-1:0] shreg_q, shreg_n;
    logic [PTR_W-1:0]  ptr_q, ptr_n, ptr_inc;
    logic              oe_q, oe_n;
    logic              busy_q, busy_n;
    logic              reg_we;
    logic [BYTE_W-1:0] regs [REG_DEPTH];
    logic [BYTE_W-1:0] rd_byte;
    logic              sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic              rx_state, byte_done;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (i2c_core_clk_i),
        .rst_n     (preset_n_i),
        .scl_i     (bus.scl_i),
        .sda_i     (bus.sda_i),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign ptr_inc   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    assign rd_byte   = regs[ptr_q];
    assign rx_state  = (state_q == ADDR) || (state_q == PTR) || (state_q == WDATA);
    assign byte_done = rx_state && scl_fall && (cnt_q == 4'd8);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        shreg_n = shreg_q;
        ptr_n   = ptr_q;
        oe_n    = oe_q;
        busy_n  = busy_q;
        reg_we  = 1'b0;
        if (stop_det) begin
            state_n = IDLE;
            cnt_n   = '0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start_det) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else begin
            if (rx_state && scl_rise && (cnt_q != 4'd8)) begin
                shreg_n = {shreg_q[BYTE_W-2:0], sda_s};
                cnt_n   = cnt_q + 4'd1;
            end
            case (state_q)
                ADDR: if (byte_done) begin
                    if (shreg_q[BYTE_W-1:1] == SLAVE_ADDR) begin
                        oe_n    = ~ACK;
                        busy_n  = 1'b1;
                        state_n = ADDR_ACK;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = WAIT_STOP;
                    end
                end
                // The R/W bit is still in shreg_q[0] when the address ACK clock ends.
                ADDR_ACK: if (scl_fall) begin
                    cnt_n = '0;
                    if (shreg_q[0]) begin
                        shreg_n = rd_byte;
                        oe_n    = ~rd_byte[BYTE_W-1];
                        state_n = RDATA;
                    end else begin
                        oe_n    = 1'b0;
                        state_n = PTR;
                    end
                end
                PTR: if (byte_done) begin
                    if ({1'b0, shreg_q} < DEPTH_EXT) begin
                        ptr_n   = shreg_q[PTR_W-1:0];
                        oe_n    = ~ACK;
                        state_n = PTR_ACK;
                    end else begin
                        state_n = WAIT_STOP;
                    end
                end
                PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    oe_n    = 1'b0;
                    cnt_n   = '0;
                    state_n = WDATA;
                end
                WDATA: if (byte_done) begin
                    reg_we  = 1'b1;
                    ptr_n   = ptr_inc;
                    oe_n    = ~ACK;
                    state_n = WDATA_ACK;
                end
                RDATA: if (scl_fall) begin
                    if (cnt_q == 4'd7) begin
                        oe_n    = 1'b0;
                        state_n = RDATA_ACK;
                    end else begin
                        shreg_n = {shreg_q[BYTE_W-2:0], 1'b0};
                        oe_n    = ~shreg_q[BYTE_W-2];
                        cnt_n   = cnt_q + 4'd1;
                    end
                end
                // cnt_q == 8 marks "master ACKed, next byte goes out on the coming fall".
                RDATA_ACK: begin
                    if (scl_rise) begin
                        ptr_n = ptr_inc;
                        if (sda_s == ACK) cnt_n = 4'd8;
                        else              state_n = WAIT_STOP;
                    end else if (scl_fall && (cnt_q == 4'd8)) begin
                        shreg_n = rd_byte;
                        oe_n    = ~rd_byte[BYTE_W-1];
                        cnt_n   = '0;
                        state_n = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i2c_core_clk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            ptr_q       <= '0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            start_o     <= 1'b0;
            stop_o      <= 1'b0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            shreg_q     <= shreg_n;
            ptr_q       <= ptr_n;
            oe_q        <= oe_n;
            busy_q      <= busy_n;
            start_o     <= start_det;
            stop_o      <= stop_det;
            wr_strobe_o <= reg_we;
            if (reg_we) begin
                wr_addr_o <= ptr_q;
                wr_data_o <= shreg_q;
            end
        end
    end

    always_ff @(posedge i2c_core_clk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            for (int unsigned i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[ptr_q] <= shreg_q;
        end
    end

    generate
        if (REG_DEPTH == (2 ** PTR_W)) begin : g_dbg_full
            assign dbg_data_o = regs[dbg_addr_i];
        end else begin : g_dbg_partial
            always_comb begin
                dbg_data_o = '0;
                if (dbg_addr_i <= PTR_LAST) dbg_data_o = regs[dbg_addr_i];
            end
        end
    endgenerate

    assign busy_o       = busy_q;
    assign bus.sda_oe_o = oe_q;

endmodule
